// File: rtl/slink_app_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one S-Link TX app port between NUM_CH sources.
// A grant is held from header through the last payload beat so packets are never interleaved.
module slink_app_tx_arbiter #(
  parameter int  NUM_CH         = 4,
  parameter int  APP_DATA_WIDTH = 32,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             link_clk,
  input  logic                             link_reset,
  input  logic [NUM_CH-1:0]                ch_enable,
  input  logic [NUM_CH-1:0]                req_sop,
  input  logic [NUM_CH*8-1:0]              req_data_id,
  input  logic [NUM_CH*16-1:0]             req_word_count,
  input  logic [NUM_CH*APP_DATA_WIDTH-1:0] req_app_data,
  output logic [NUM_CH-1:0]                req_advance,
  output logic                             tx_sop,
  output logic [7:0]                       tx_data_id,
  output logic [15:0]                      tx_word_count,
  output logic [APP_DATA_WIDTH-1:0]        tx_app_data,
  input  logic                             tx_advance,
  output logic                             busy,
  output logic [CH_W-1:0]                  grant_ch,
  output logic [1:0]                       dbg_state
);

  // Handshake: the granted source holds sop/id/wc/data stable until it sees
  // req_advance; a beat is consumed in the cycle where tx_advance is high while
  // the arbiter is in HDR or DATA. tx_advance in IDLE has no effect.

  localparam logic [15:0] BPB          = 16'(APP_DATA_WIDTH / 8);
  localparam logic [7:0]  SHORT_ID_MAX = 8'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                    state;
  logic [CH_W-1:0]           rr_ptr;
  logic [15:0]               remaining;
  logic [7:0]                hdr_id;
  logic [15:0]               hdr_wc;

  logic [NUM_CH-1:0]         eligible;
  logic                      pick_valid;
  logic [CH_W-1:0]           pick_ch;
  logic [CH_W-1:0]           pick_next;

  logic                      sel_sop;
  logic [7:0]                sel_id;
  logic [15:0]               sel_wc;
  logic [APP_DATA_WIDTH-1:0] sel_data;

  assign eligible = req_sop & ch_enable;

  // First eligible channel at or after rr_ptr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_valid && eligible[(int'(rr_ptr) + i) % NUM_CH]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  assign pick_next = (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + CH_W'(1);

  assign sel_sop  = req_sop[grant_ch];
  assign sel_id   = req_data_id[int'(grant_ch) * 8 +: 8];
  assign sel_wc   = req_word_count[int'(grant_ch) * 16 +: 16];
  assign sel_data = req_app_data[int'(grant_ch) * APP_DATA_WIDTH +: APP_DATA_WIDTH];

  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_ch  <= '0;
      remaining <= '0;
      hdr_id    <= '0;
      hdr_wc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_ch <= pick_ch;
            rr_ptr   <= pick_next;
            state    <= HDR;
          end
        end
        HDR: begin
          if (tx_advance) begin
            hdr_id <= sel_id;
            hdr_wc <= sel_wc;
            // The header beat already carries the first BPB payload bytes.
            if (sel_id <= SHORT_ID_MAX || sel_wc <= BPB) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= sel_wc - BPB;
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (tx_advance) begin
            if (remaining <= BPB) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining - BPB;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_advance   = '0;
    tx_sop        = 1'b0;
    tx_data_id    = '0;
    tx_word_count = '0;
    tx_app_data   = '0;
    case (state)
      HDR: begin
        tx_sop                = sel_sop;
        tx_data_id            = sel_id;
        tx_word_count         = sel_wc;
        tx_app_data           = sel_data;
        req_advance[grant_ch] = tx_advance;
      end
      DATA: begin
        tx_data_id            = hdr_id;
        tx_word_count         = hdr_wc;
        tx_app_data           = sel_data;
        req_advance[grant_ch] = tx_advance;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
